hazard_freeze_ctrl: RTL and testbench
=====================================

HAZARD_FREEZE_CTRL -- requirements
Module: hazard_freeze_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the number of consecutive memory-wait cycles tolerated before a timeout error (range 1..255).
REQ-002 SHALL have parameter REG_AW, default 3, meaning the register-address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_src1, id_src2  in  REG_AW each  source registers of the instruction in ID.
REQ-006 id_src1_used, id_src2_used  in  1 each  the corresponding source is actually read.
REQ-007 ex_load  in  1  the instruction in EX is a load.
REQ-008 ex_op_dest  in  REG_AW  destination register of the EX instruction.
REQ-009 mem_req  in  1  the MEM-stage instruction accesses data memory this cycle.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 freeze_if, freeze_id  out  1 each  hold the PC and the IF/ID register.
REQ-012 bubble_ex  out  1  load a NOP into ID/EX instead of the ID instruction.
REQ-013 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB (the stall input of the back-end pipeline registers).
REQ-014 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, MEM_WAIT and ERROR, with a wait counter of width clog2(MAX_WAIT+1).
REQ-016 Load-use hazard = ex_load & ex_op_dest!=0 & ((id_src1_used & id_src1==ex_op_dest) | (id_src2_used & id_src2==ex_op_dest)); register 0 SHALL never create a hazard.
REQ-017 Mem-wait condition = mem_req & !mem_ready.
REQ-018 All outputs SHALL be combinational from the current state and inputs in the same cycle (zero latency); only the state, counter and mem_err are registered.
REQ-019 In IDLE with mem-wait false and hazard true: freeze_if=freeze_id=bubble_ex=1 and freeze=0, for exactly the cycles in which the hazard holds (one cycle per load-use pair in normal flow).
REQ-020 In IDLE with mem-wait true: freeze=freeze_if=freeze_id=1 and bubble_ex=0; the next state SHALL be MEM_WAIT with counter=1.
REQ-021 Simultaneous mem-wait and hazard SHALL give priority to mem-wait (no bubble). The hazard SHALL be re-evaluated once the freeze releases.
REQ-022 In MEM_WAIT with mem-wait true: outputs are as in REQ-020 and the counter increments; when the counter would exceed MAX_WAIT, the next state SHALL be ERROR.
REQ-023 In MEM_WAIT with mem_ready=1: freeze=0 in that same cycle, load-use rules of REQ-019 apply, the next state SHALL be IDLE and the counter SHALL clear.
REQ-024 mem_req dropping without mem_ready while in MEM_WAIT SHALL be treated as completion (return to IDLE).
REQ-025 ERROR: freeze=freeze_if=freeze_id=1, bubble_ex=0, mem_err=1; the block SHALL remain in ERROR until reset.
REQ-026 bubble_ex SHALL never be 1 while freeze=1.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, counter=0 and mem_err=0, and SHALL drive all outputs to 0 regardless of other inputs.
REQ-028 Reset asserted mid-wait or in ERROR SHALL abandon the wait with no residual freeze after release.

Configuration
REQ-029 With HAZARD_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits). It counts cycles with freeze_if=1, saturates at 0xFFFF, and resets to 0.
REQ-030 Without HAZARD_STALL_CNT_EN, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 The FSM state enum and the REG_AW default SHALL live in the shared package cpu_pkg.
REQ-032 A sub-module hazard_detect SHALL hold the purely combinational load-use compare; the FSM and counters stay in hazard_freeze_ctrl.

Verification
REQ-033 ex_load=1, ex_op_dest=3, id_src1=3, id_src1_used=1, no mem_req -> freeze_if=freeze_id=bubble_ex=1 and freeze=0 for 1 cycle.
REQ-034 Same as REQ-033 but ex_op_dest=0, or id_src1_used=0 -> all outputs 0.
REQ-035 mem_req=1 with mem_ready low for 4 cycles, then high -> freeze=1 for 4 cycles, 0 in the ready cycle, state back in IDLE.
REQ-036 Load-use hazard together with mem-wait for 2 cycles -> bubble_ex=0 during the wait; bubble_ex=1 in the ready cycle if the hazard persists.
REQ-037 MAX_WAIT=3 with mem_ready held low -> mem_err=1 after the 4th wait cycle; freeze stays 1; rst returns all outputs to 0.
REQ-038 With HAZARD_STALL_CNT_EN defined, 5 stall cycles -> stall_cnt=5; force 0xFFFF -> it holds at 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: freeze-controller FSM states and register-file address width.
package cpu_pkg;

  localparam int REG_AW_DEF = 3;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } freeze_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_op_dest,
  output logic              hazard
);

  logic src1_hit;
  logic src2_hit;

  // Register 0 is hardwired to zero, so a load targeting it never forwards a value.
  always_comb begin
    src1_hit = id_src1_used && (id_src1 == ex_op_dest);
    src2_hit = id_src2_used && (id_src2 == ex_op_dest);
    hazard   = ex_load && (ex_op_dest != '0) && (src1_hit || src2_hit);
  end

endmodule

// File: rtl/hazard_freeze_ctrl.sv
// Pipeline freeze/bubble controller for load-use hazards and slow data memory.
// Optional stall_cnt output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_freeze_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_op_dest,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_id,
  output logic              bubble_ex,
  output logic              freeze,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  freeze_state_e    state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             hazard;
  logic             mem_wait;
  int               next_cnt;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .ex_load      (ex_load),
    .ex_op_dest   (ex_op_dest),
    .hazard       (hazard)
  );

  // Memory wait outranks the load-use bubble; outputs are zero-latency from state and inputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    freeze_if  = 1'b0;
    freeze_id  = 1'b0;
    bubble_ex  = 1'b0;
    freeze     = 1'b0;
    mem_wait   = mem_req && !mem_ready;
    next_cnt   = int'(wait_cnt_q) + 1;

    case (state_q)
      IDLE: begin
        if (mem_wait) begin
          freeze_if  = 1'b1;
          freeze_id  = 1'b1;
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else if (hazard) begin
          freeze_if = 1'b1;
          freeze_id = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          freeze_if = 1'b1;
          freeze_id = 1'b1;
          freeze    = 1'b1;
          if (next_cnt > MAX_WAIT) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = CNT_W'(next_cnt);
          end
        end else begin
          // Ready, or request withdrawn: the back end releases and the hazard is re-checked.
          freeze_if  = hazard;
          freeze_id  = hazard;
          bubble_ex  = hazard;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        freeze_if = 1'b1;
        freeze_id = 1'b1;
        freeze    = 1'b1;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (rst) begin
      freeze_if = 1'b0;
      freeze_id = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of front-end stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_if && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_freeze_ctrl.sv
// Self-checking bench for hazard_freeze_ctrl: two instances (MAX_WAIT 15 and 3) on shared
// inputs, directed sequences plus randomized traffic checked against a behavioural model.
module tb_hazard_freeze_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_src1, id_src2, ex_op_dest;
  logic       id_src1_used, id_src2_used, ex_load, mem_req, mem_ready;

  logic       fi0, fd0, bx0, fz0, me0;
  logic       fi1, fd1, bx1, fz1, me1;
  logic [4:0] act [2];
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] sc0, sc1;
`endif

  int checksTotal  = 0;
  int checksPassed = 0;

  int  modelRun   [2];
  int  nextRun    [2];
  bit  modelErr   [2];
  bit  nextErr    [2];
  int  modelStall [2];
  int  nextStall  [2];
  logic       mHz, mMw;
  logic [4:0] mExp;

  always #5 clk = ~clk;

  hazard_freeze_ctrl #(.MAX_WAIT(15), .REG_AW(3)) dut0 (
    .clk (clk), .rst (rst),
    .id_src1 (id_src1), .id_src2 (id_src2),
    .id_src1_used (id_src1_used), .id_src2_used (id_src2_used),
    .ex_load (ex_load), .ex_op_dest (ex_op_dest),
    .mem_req (mem_req), .mem_ready (mem_ready),
    .freeze_if (fi0), .freeze_id (fd0), .bubble_ex (bx0), .freeze (fz0),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt (sc0),
`endif
    .mem_err (me0)
  );

  hazard_freeze_ctrl #(.MAX_WAIT(3), .REG_AW(3)) dut1 (
    .clk (clk), .rst (rst),
    .id_src1 (id_src1), .id_src2 (id_src2),
    .id_src1_used (id_src1_used), .id_src2_used (id_src2_used),
    .ex_load (ex_load), .ex_op_dest (ex_op_dest),
    .mem_req (mem_req), .mem_ready (mem_ready),
    .freeze_if (fi1), .freeze_id (fd1), .bubble_ex (bx1), .freeze (fz1),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt (sc1),
`endif
    .mem_err (me1)
  );

  assign act[0] = {fi0, fd0, bx0, fz0, me0};
  assign act[1] = {fi1, fd1, bx1, fz1, me1};

  function automatic int maxWait(input int k);
    return (k == 0) ? 15 : 3;
  endfunction

  // Output vector order: {freeze_if, freeze_id, bubble_ex, freeze, mem_err}
  task automatic checkVec(input string name, input logic [4:0] a, input logic [4:0] e);
    checksTotal++;
    if (a === e) checksPassed++;
    else $display("[TB] FAIL %s: got %b expected %b at %0t", name, a, e, $time);
  endtask

  task automatic checkOutput(input string name, input int k, input logic [4:0] e);
    @(negedge clk);
    checkVec(name, act[k], e);
  endtask

  task automatic applyStimulus(input logic r, input logic lo, input logic [2:0] dest,
                               input logic [2:0] s1, input logic u1,
                               input logic [2:0] s2, input logic u2,
                               input logic req, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; ex_load = lo; ex_op_dest = dest;
    id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    mem_req = req; mem_ready = rdy;
  endtask

  // Reference: consecutive un-ready memory cycles are counted; exceeding MAX_WAIT latches an error.
  always @(negedge clk) begin
    mHz = ex_load && (ex_op_dest != 3'd0) &&
          ((id_src1_used && id_src1 == ex_op_dest) || (id_src2_used && id_src2 == ex_op_dest));
    mMw = mem_req && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mExp = 5'b00000; nextRun[k] = 0; nextErr[k] = 1'b0;
      end else if (modelErr[k]) begin
        mExp = 5'b11011; nextRun[k] = modelRun[k]; nextErr[k] = 1'b1;
      end else if (mMw) begin
        mExp = 5'b11010; nextRun[k] = modelRun[k] + 1;
        nextErr[k] = (modelRun[k] + 1 > maxWait(k));
      end else begin
        mExp = mHz ? 5'b11100 : 5'b00000; nextRun[k] = 0; nextErr[k] = 1'b0;
      end
      checkVec($sformatf("model_k%0d", k), act[k], mExp);
      checksTotal++;
      if (!(act[k][2] && act[k][1])) checksPassed++;
      else $display("[TB] FAIL bubble_vs_freeze_k%0d: got %b expected bubble_ex&freeze=0", k, act[k]);
      if (rst) nextStall[k] = 0;
      else if (mExp[4] && modelStall[k] < 65535) nextStall[k] = modelStall[k] + 1;
      else nextStall[k] = modelStall[k];
`ifdef HAZARD_STALL_CNT_EN
      checksTotal++;
      if (((k == 0) ? sc0 : sc1) === (rst ? 16'd0 : 16'(modelStall[k]))) checksPassed++;
      else $display("[TB] FAIL stall_cnt_k%0d: got %0d expected %0d", k,
                    (k == 0) ? sc0 : sc1, rst ? 0 : modelStall[k]);
`endif
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      modelRun[k]   <= nextRun[k];
      modelErr[k]   <= nextErr[k];
      modelStall[k] <= nextStall[k];
    end
  end

  initial begin
    rst = 1'b1; ex_load = 1'b1; ex_op_dest = 3'd3; id_src1 = 3'd3; id_src1_used = 1'b1;
    id_src2 = 3'd0; id_src2_used = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    checkOutput("reset_outputs", 0, 5'b00000);
    checkOutput("reset_outputs_k1", 1, 5'b00000);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 3, 1, 0, 0, 0, 0); checkOutput("lu_hazard", 0, 5'b11100);
    applyStimulus(0, 0, 0, 3, 1, 0, 0, 0, 0); checkOutput("lu_after_bubble", 0, 5'b00000);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0); checkOutput("lu_r0", 0, 5'b00000);
    applyStimulus(0, 1, 3, 3, 0, 0, 0, 0, 0); checkOutput("lu_unused", 0, 5'b00000);
    applyStimulus(0, 1, 5, 0, 0, 5, 1, 0, 0); checkOutput("lu_src2", 0, 5'b11100);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("mem_wait", 0, 5'b11010);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("mem_ready", 0, 5'b00000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("wait_again", 0, 5'b11010);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("req_drop", 0, 5'b00000);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 3, 3, 1, 0, 0, 1, 0); checkOutput("wait_hazard", 0, 5'b11010);
    end
    applyStimulus(0, 1, 3, 3, 1, 0, 0, 1, 1); checkOutput("ready_hazard", 0, 5'b11100);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("rst_mid", 1, 5'b00000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("after_rst", 1, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("timeout_wait", 1, 5'b11010);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("timeout_err", 1, 5'b11011);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("err_sticky", 1, 5'b11011);
    applyStimulus(1, 1, 3, 3, 1, 0, 0, 1, 0); checkOutput("err_rst", 1, 5'b00000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("no_residual", 1, 5'b00000);

    for (int i = 0; i < 1500; i++) begin
      logic [2:0] d, s1, s2;
      d  = 3'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 2) == 0) ? d : 3'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 2) == 0) ? d : 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), d,
                    s1, 1'($urandom_range(0, 1)), s2, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6));
    end

`ifdef HAZARD_STALL_CNT_EN
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 3, 3, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checksTotal++;
    if (sc0 === 16'd5) checksPassed++;
    else $display("[TB] FAIL stall_cnt_five: got %0d expected 5", sc0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    checksTotal++;
    if (sc0 === 16'hFFFF) checksPassed++;
    else $display("[TB] FAIL stall_cnt_sat: got %h expected ffff", sc0);
`endif

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
